gf180mcu_fd_sc_mcu9t5v0__oai33_arcgen: RTL and testbench

Sequential stimulus and check engine for the oai33 cell: the driving end of its timing-arc interface. It walks every conditional arc the cell declares (6 input pins × 8 side conditions, including the ifnone case), drives the pin-under-test low, high, then low. After each step it samples ZN against the OAI33 function ZN = !((A1|A2|A3)&(B1|B2|B3)). It sits in the library's silicon/FPGA bring-up harness, wired directly to one oai33 instance, and reports pass/fail per arc.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__arcgen_pkg.sv | 10 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__arcgen_vec.sv | 15 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__oai33_arcgen.sv | 96 +++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__oai33_arcgen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arcgen_pkg.sv
// gf180mcu_fd_sc_mcu9t5v0__arcgen_pkg: shared types, constants and OAI33 reference for the arc generator
package gf180mcu_fd_sc_mcu9t5v0__arcgen_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;
  typedef enum logic [1:0] {PH_INIT, PH_RISE, PH_FALL} phase_t;
  localparam logic [2:0] PIN_A1 = 3'd0, PIN_B1 = 3'd3;
  localparam int NUM_ARCS = 48, NUM_PHASES = 3;
  function automatic logic oai33_exp(input logic [2:0] a, input logic [2:0] b);
    return ~(|a & |b);
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__arcgen_vec.sv
// gf180mcu_fd_sc_mcu9t5v0__arcgen_vec: maps (arc, phase) to the drive vector {A1,A2,A3,B1,B2,B3}
import gf180mcu_fd_sc_mcu9t5v0__arcgen_pkg::*;
module gf180mcu_fd_sc_mcu9t5v0__arcgen_vec (
  input  logic [5:0] arc,
  input  phase_t     ph,
  output logic [5:0] vec
);
  logic [2:0] pin, cond, sel, hot;
  assign pin = arc[5:3];
  assign cond = arc[2:0];
  assign sel = pin - (pin < PIN_B1 ? PIN_A1 : PIN_B1);
  assign hot = ph == PH_RISE ? 3'b100 >> sel : 3'b000;
  // cond always drives the opposite group, MSB first
  assign vec = pin < PIN_B1 ? {hot, cond} : {cond, hot};
endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai33_arcgen.sv
// gf180mcu_fd_sc_mcu9t5v0__oai33_arcgen: sweeps every conditional arc of an oai33 cell and checks ZN
import gf180mcu_fd_sc_mcu9t5v0__arcgen_pkg::*;
module gf180mcu_fd_sc_mcu9t5v0__oai33_arcgen #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       zn,
  output logic       a1,
  output logic       a2,
  output logic       a3,
  output logic       b1,
  output logic       b2,
  output logic       b3,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [5:0] arc_idx,
  output logic [5:0] fail_arc,
  output logic [1:0] fail_ph
);
  state_t state, nxt;
  phase_t ph;
  logic [5:0] drv, vec;
  logic [7:0] cnt;
  logic miss, last_ph;
  gf180mcu_fd_sc_mcu9t5v0__arcgen_vec u_vec (.arc(arc_idx), .ph(ph), .vec(vec));
  assign {a1, a2, a3, b1, b2, b3} = drv;
  assign busy = state inside {S_DRIVE, S_WAIT, S_CHECK};
  assign done = state == S_DONE;
  assign miss = zn != oai33_exp(drv[5:3], drv[2:0]);
  assign last_ph = ph == phase_t'(NUM_PHASES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = start && !abort ? S_DRIVE : S_IDLE;
      S_DRIVE: nxt = SETTLE == 0 ? S_CHECK : S_WAIT;
      S_WAIT:  nxt = cnt == 8'(SETTLE - 1) ? S_CHECK : S_WAIT;
      S_CHECK: nxt = last_ph && arc_idx == 6'(NUM_ARCS - 1) ? S_DONE : S_DRIVE;
      default: nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) nxt = S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      drv <= '0;
      ph <= PH_INIT;
      cnt <= '0;
      err <= 1'b0;
      err_cnt <= '0;
      arc_idx <= '0;
      fail_arc <= '0;
      fail_ph <= '0;
    end else if (abort && state != S_IDLE) begin
      drv <= '0;
      ph <= PH_INIT;
      cnt <= '0;
    end else
      case (state)
        S_IDLE:
          if (start && !abort) begin
            ph <= PH_INIT;
            err <= 1'b0;
            err_cnt <= '0;
            arc_idx <= '0;
            fail_arc <= '0;
            fail_ph <= '0;
          end
        S_DRIVE: begin
          drv <= vec;
          cnt <= '0;
        end
        S_WAIT: cnt <= cnt + 8'd1;
        S_CHECK: begin
          if (miss) begin
            err <= 1'b1;
            err_cnt <= err_cnt == 8'hff ? err_cnt : err_cnt + 8'd1;
            // only the first mismatch of a sweep is recorded
            if (!err) begin
              fail_arc <= arc_idx;
              fail_ph <= ph;
            end
          end
          ph <= last_ph ? PH_INIT : phase_t'(ph + 2'd1);
          if (last_ph && arc_idx != 6'(NUM_ARCS - 1)) arc_idx <= arc_idx + 6'd1;
        end
        S_DONE: drv <= '0;
        default: drv <= '0;
      endcase
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__oai33_arcgen.sv
// tb_gf180mcu_fd_sc_mcu9t5v0__oai33_arcgen: directed checks of the oai33 arc generator
module tb_gf180mcu_fd_sc_mcu9t5v0__oai33_arcgen;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, stuck = 1'b0;
  logic zn, a1, a2, a3, b1, b2, b3, busy, done, err;
  logic [7:0] err_cnt;
  logic [5:0] arc_idx, fail_arc;
  logic [1:0] fail_ph;
  int n_checks = 0, n_fail = 0, done_cnt = 0;
  logic [2:0] cap_a[3], cap_b[3];
  logic cap_z[3];
  logic err19, err20;

  gf180mcu_fd_sc_mcu9t5v0__oai33_arcgen #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .zn(zn),
    .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt),
    .arc_idx(arc_idx), .fail_arc(fail_arc), .fail_ph(fail_ph)
  );

  // ideal cell, or ZN stuck high
  assign zn = stuck ? 1'b1 : ~((a1 | a2 | a3) & (b1 | b2 | b3));

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  // starts a sweep and follows it to the end; n counts edges after the accepting edge
  task automatic run_sweep(input bit hold, output int cyc);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    cyc = 0;
    while (busy && cyc < 3000) begin
      if (cyc == 15 || cyc == 19 || cyc == 23) begin
        cap_a[(cyc - 15) / 4] = {a1, a2, a3};
        cap_b[(cyc - 15) / 4] = {b1, b2, b3};
        cap_z[(cyc - 15) / 4] = zn;
      end
      if (cyc == 19) err19 = err;
      if (cyc == 20) err20 = err;
      cyc++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'($urandom);
    abort = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({a1, a2, a3, b1, b2, b3, busy, done, err, err_cnt, arc_idx, fail_arc, fail_ph} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {a1, a2, a3, b1, b2, b3, busy, done, err, err_cnt, arc_idx, fail_arc, fail_ph});
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if ({a1, a2, a3, b1, b2, b3, busy, done, err, err_cnt, arc_idx, fail_arc, fail_ph} !== 32'd0) begin
      n_fail++;
      $display("FAIL idle_hold: got %h required 0", {a1, a2, a3, b1, b2, b3, busy, done, err, err_cnt, arc_idx, fail_arc, fail_ph});
    end
  endtask

  task automatic test_sweep();
    int cyc;
    logic [2:0] ea[3] = '{3'b000, 3'b100, 3'b000};
    logic ez[3] = '{1'b1, 1'b0, 1'b1};
    stuck = 1'b0;
    run_sweep(1'b0, cyc);
    n_checks++;
    if (cyc !== 576) begin n_fail++; $display("FAIL busy_cycles: got %0d required 576", cyc); end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b required 1", done); end
    n_checks++;
    if (err !== 1'b0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL clean_err: got err=%b cnt=%0d required 0/0", err, err_cnt); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cap_a[i] !== ea[i] || cap_b[i] !== 3'b001 || cap_z[i] !== ez[i]) begin
        n_fail++;
        $display("FAIL arc1_phase%0d: got A=%b B=%b ZN=%b required A=%b B=001 ZN=%b", i, cap_a[i], cap_b[i], cap_z[i], ea[i], ez[i]);
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || {a1, a2, a3, b1, b2, b3} !== 6'd0) begin
      n_fail++;
      $display("FAIL after_done: got done=%b drive=%b required 0/000000", done, {a1, a2, a3, b1, b2, b3});
    end
  endtask

  task automatic test_stuck();
    int cyc;
    stuck = 1'b1;
    run_sweep(1'b0, cyc);
    n_checks++;
    if (cyc !== 576) begin n_fail++; $display("FAIL stuck_cycles: got %0d required 576", cyc); end
    n_checks++;
    if (err_cnt !== 8'd42 || err !== 1'b1) begin n_fail++; $display("FAIL stuck_count: got err=%b cnt=%0d required 1/42", err, err_cnt); end
    n_checks++;
    if (fail_arc !== 6'd1 || fail_ph !== 2'd1) begin n_fail++; $display("FAIL stuck_first: got arc=%0d ph=%0d required 1/1", fail_arc, fail_ph); end
    n_checks++;
    if (err19 !== 1'b0 || err20 !== 1'b1) begin n_fail++; $display("FAIL err_timing: got %b%b required 01", err19, err20); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_abort();
    int dc;
    stuck = 1'b1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    abort = 1'b1;
    dc = done_cnt;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || {a1, a2, a3, b1, b2, b3} !== 6'd0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b drive=%b required 0/000000", busy, {a1, a2, a3, b1, b2, b3});
    end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt !== dc) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt - dc); end
    n_checks++;
    if (err_cnt !== 8'd7 || err !== 1'b1 || fail_arc !== 6'd1 || fail_ph !== 2'd1) begin
      n_fail++;
      $display("FAIL abort_retain: got cnt=%0d err=%b arc=%0d ph=%0d required 7/1/1/1", err_cnt, err, fail_arc, fail_ph);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    stuck = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if ({a1, a2, a3, b1, b2, b3} !== 6'b100000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wait_drive: got drive=%b busy=%b required 100000/1", {a1, a2, a3, b1, b2, b3}, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({a1, a2, a3, b1, b2, b3, busy, done, err, err_cnt, arc_idx, fail_arc, fail_ph} !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h required 0", {a1, a2, a3, b1, b2, b3, busy, done, err, err_cnt, arc_idx, fail_arc, fail_ph});
    end
    #1 rst = 1'b0;
    run_sweep(1'b0, cyc);
    n_checks++;
    if (cyc !== 576 || done !== 1'b1 || err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset_sweep: got cyc=%0d done=%b cnt=%0d required 576/1/0", cyc, done, err_cnt);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_priority();
    int cyc;
    stuck = 1'b0;
    run_sweep(1'b1, cyc);
    n_checks++;
    if (cyc !== 576) begin n_fail++; $display("FAIL start_held: got %0d cycles required 576", cyc); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy: got %b required 0", busy); end
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || {a1, a2, a3, b1, b2, b3} !== 6'd0) begin
      n_fail++;
      $display("FAIL start_abort_idle: got busy=%b drive=%b required 0/000000", busy, {a1, a2, a3, b1, b2, b3});
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_stuck();
    test_abort();
    test_async_reset();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
